cp0_eret_unit: RTL and testbench
================================

CP0_ERET_UNIT -- requirements
Module: cp0_eret_unit

Interface
REQ-001 Parameter RESET_IE, default 1'b1, is the reset value of STATUS.IE.
REQ-002 Parameter EPC_MASK, default 32'hFFFF_FFFC, is ANDed into every value written to EPC (word alignment).
REQ-003 clk  input  1  single pipeline clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 exc_req  input  1  exception taken this cycle (overflow/undefined from the exception path).
REQ-006 exc_code  input  5  ExcCode of the exception; sampled only when exc_req=1.
REQ-007 exc_pc  input  32  PC of the faulting Memory-stage instruction.
REQ-008 eret_m  input  1  ERET instruction in Memory stage.
REQ-009 mtc0_we  input  1  CP0 register write strobe.
REQ-010 mtc0_addr  input  5  CP0 register number for write.
REQ-011 mtc0_wdata  input  32  CP0 write data.
REQ-012 mfc0_addr  input  5  CP0 register number for read.
REQ-013 mfc0_rdata  output  32  CP0 read data, combinational from mfc0_addr.
REQ-014 ret_redirect  output  1  one-cycle pulse: PC mux selects ret_pc.
REQ-015 ret_pc  output  32  return target, equal to EPC.
REQ-016 ret_flush  output  1  one-cycle pulse flushing Decode, Execute and Memory on return.
REQ-017 exl  output  1  STATUS.EXL, high while the handler runs.

Function
REQ-018 Registers: STATUS (12) bit1 EXL, bit0 IE, other bits read 0; CAUSE (13) bits[6:2] ExcCode, other bits read 0; EPC (14) full 32 bits.
REQ-019 Unimplemented register numbers SHALL read 32'h0; writes to them SHALL be ignored.
REQ-020 FSM states: RUN, HANDLER, RETURN; encoding lives in the package.
REQ-021 RUN + exc_req: EPC<=exc_pc&EPC_MASK, CAUSE.ExcCode<=exc_code, EXL<=1, next HANDLER.
REQ-022 HANDLER + exc_req (nested): CAUSE.ExcCode updated, EPC and EXL unchanged, stay HANDLER.
REQ-023 HANDLER + eret_m (no exc_req): EXL<=0, next RETURN.
REQ-024 RETURN: ret_redirect=1 and ret_flush=1 for exactly that one cycle, ret_pc=EPC; next RUN unconditionally.
REQ-025 Latency: eret_m high in cycle N produces ret_redirect in cycle N+1.
REQ-026 eret_m in RUN (ERET outside handler): ignored, no redirect, no state change.
REQ-027 exc_req and eret_m in the same cycle: exception wins, eret_m discarded.
REQ-028 exc_req during RETURN: redirect still issued this cycle; exception captured as in REQ-021, next HANDLER.
REQ-029 mtc0 write and exception capture in the same cycle: capture wins for the EPC, ExcCode and EXL fields; other written fields apply.
REQ-030 mtc0 to EPC in HANDLER SHALL change the return target (EPC_MASK applied).
REQ-031 mfc0_rdata SHALL reflect register contents before the current edge (no write-through).
REQ-032 ret_pc SHALL equal EPC in all states; ret_redirect and ret_flush SHALL be 0 outside RETURN.

Reset
REQ-033 On rst_n=0: state RUN, EPC=0, CAUSE=0, EXL=0, IE=RESET_IE, ret_redirect=0, ret_flush=0.
REQ-034 Reset mid-HANDLER or mid-RETURN SHALL drop any pending redirect; there is no redirect pulse after release.

Configuration
REQ-035 Macro CP0_COUNT_EN defined: register 9 COUNT is a 32-bit counter, +1 every cycle, wrapping 32'hFFFF_FFFF->0, mtc0-writable (write wins over increment), reset 0.
REQ-036 Macro CP0_COUNT_EN undefined: register 9 is unimplemented per REQ-019 and no counter logic is present.

Structure
REQ-037 Package cp0_pkg SHALL hold register numbers (9, 12, 13, 14), ExcCode constants (EXC_RI=5'd10, EXC_OV=5'd12) and the FSM state type.
REQ-038 Sub-module cp0_count SHALL implement the COUNT register; instantiated only under CP0_COUNT_EN.

Verification
REQ-039 exc_req=1, exc_code=12, exc_pc=32'h0040_0010 in RUN -> next cycle EPC=32'h0040_0010, CAUSE=32'h30, exl=1, state HANDLER.
REQ-040 After REQ-039, eret_m pulse at cycle N -> cycle N+1: ret_redirect=1, ret_flush=1, ret_pc=32'h0040_0010, exl=0; cycle N+2: both pulses 0.
REQ-041 HANDLER, second exc_req with exc_code=10 -> CAUSE=32'h28, EPC unchanged, no redirect.
REQ-042 Same-cycle exc_req and eret_m in HANDLER -> no ret_redirect, CAUSE updated; mtc0 EPC=32'h0000_1003 -> mfc0 reads 32'h0000_1000.
REQ-043 rst_n low for 1 cycle in HANDLER -> exl=0, STATUS reads 32'h1, no ret_redirect afterwards; eret_m in RUN -> no redirect.
REQ-044 With CP0_COUNT_EN: mtc0 COUNT=32'hFFFF_FFFE -> reads ...FFFE, ...FFFF, 0 on consecutive cycles; without it, mfc0 reg 9 -> 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes and the return-sequencer state type.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT  = 5'd9;
  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  localparam logic [4:0] EXC_RI = 5'd10;
  localparam logic [4:0] EXC_OV = 5'd12;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_RETURN  = 2'd2
  } state_t;

endpackage

// File: rtl/cp0_count.sv
// CP0 COUNT register: free-running 32-bit cycle counter, wraps to 0.
// One-cycle write latency; a write in the same cycle takes precedence over the increment.
module cp0_count (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'h0;
    end else if (we) begin
      count <= wdata;
    end else begin
      count <= count + 32'h1;
    end
  end

endmodule

// File: rtl/cp0_eret_unit.sv
// CP0 STATUS/CAUSE/EPC with exception capture and ERET return sequencing; redirect one cycle after eret_m, no backpressure.
// Optional COUNT register (reg 9) is built only when CP0_COUNT_EN is defined.
module cp0_eret_unit
  import cp0_pkg::*;
#(
  parameter logic        RESET_IE = 1'b1,
  parameter logic [31:0] EPC_MASK = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        eret_m,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_wdata,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_rdata,
  output logic        ret_redirect,
  output logic [31:0] ret_pc,
  output logic        ret_flush,
  output logic        exl
);

  state_t      state;
  logic [31:0] epc;
  logic [4:0]  cause_code;
  logic        ie;

`ifdef CP0_COUNT_EN
  logic [31:0] count;

  cp0_count u_count (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mtc0_we && (mtc0_addr == REG_COUNT)),
    .wdata (mtc0_wdata),
    .count (count)
  );
`endif

  assign ret_pc = epc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      epc          <= 32'h0;
      cause_code   <= 5'h0;
      exl          <= 1'b0;
      ie           <= RESET_IE;
      ret_redirect <= 1'b0;
      ret_flush    <= 1'b0;
    end else begin
      ret_redirect <= 1'b0;
      ret_flush    <= 1'b0;

      // Software writes land first so that exception capture below overrides the fields it owns.
      if (mtc0_we) begin
        case (mtc0_addr)
          REG_STATUS: begin
            ie  <= mtc0_wdata[0];
            exl <= mtc0_wdata[1];
          end
          REG_CAUSE: cause_code <= mtc0_wdata[6:2];
          REG_EPC:   epc        <= mtc0_wdata & EPC_MASK;
          default:   ;
        endcase
      end

      case (state)
        ST_RUN, ST_RETURN: begin
          if (exc_req) begin
            epc        <= exc_pc & EPC_MASK;
            cause_code <= exc_code;
            exl        <= 1'b1;
            state      <= ST_HANDLER;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_HANDLER: begin
          // A nested exception only refreshes the cause; the original return address is kept.
          if (exc_req) begin
            cause_code <= exc_code;
          end else if (eret_m) begin
            exl          <= 1'b0;
            state        <= ST_RETURN;
            ret_redirect <= 1'b1;
            ret_flush    <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    mfc0_rdata = 32'h0;
    case (mfc0_addr)
      REG_STATUS: mfc0_rdata = {30'h0, exl, ie};
      REG_CAUSE:  mfc0_rdata = {25'h0, cause_code, 2'b00};
      REG_EPC:    mfc0_rdata = epc;
`ifdef CP0_COUNT_EN
      REG_COUNT:  mfc0_rdata = count;
`endif
      default:    mfc0_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_eret_unit.sv
// Directed bench for cp0_eret_unit: exception capture, ERET return pulse, nesting, reset and COUNT (CP0_COUNT_EN).
module tb_cp0_eret_unit;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        eret_m;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_rdata;
  logic        ret_redirect;
  logic [31:0] ret_pc;
  logic        ret_flush;
  logic        exl;

  int total  = 0;
  int passed = 0;

  cp0_eret_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .exc_req      (exc_req),
    .exc_code     (exc_code),
    .exc_pc       (exc_pc),
    .eret_m       (eret_m),
    .mtc0_we      (mtc0_we),
    .mtc0_addr    (mtc0_addr),
    .mtc0_wdata   (mtc0_wdata),
    .mfc0_addr    (mfc0_addr),
    .mfc0_rdata   (mfc0_rdata),
    .ret_redirect (ret_redirect),
    .ret_pc       (ret_pc),
    .ret_flush    (ret_flush),
    .exl          (exl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    mfc0_addr = addr;
    #1;
    chk(tag, mfc0_rdata, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; exc_req = 1'b0; exc_code = 5'h0; exc_pc = 32'h0; eret_m = 1'b0;
    mtc0_we = 1'b0; mtc0_addr = 5'h0; mtc0_wdata = 32'h0; mfc0_addr = 5'h0;

    tick();
    chk("rst_redirect", {31'h0, ret_redirect}, 32'h0);
    chk("rst_flush",    {31'h0, ret_flush},    32'h0);
    chk("rst_exl",      {31'h0, exl},          32'h0);
    chk("rst_ret_pc",   ret_pc,                32'h0);
    rd("rst_status", REG_STATUS, 32'h1);
    rd("rst_cause",  REG_CAUSE,  32'h0);
    rd("rst_epc",    REG_EPC,    32'h0);
    rst_n = 1'b1;
    tick();

    // First exception from RUN
    exc_req = 1'b1; exc_code = EXC_OV; exc_pc = 32'h0040_0010;
    tick();
    exc_req = 1'b0;
    rd("exc_epc",    REG_EPC,    32'h0040_0010);
    rd("exc_cause",  REG_CAUSE,  32'h30);
    rd("exc_status", REG_STATUS, 32'h3);
    chk("exc_exl",      {31'h0, exl},          32'h1);
    chk("exc_redirect", {31'h0, ret_redirect}, 32'h0);

    // ERET: redirect exactly one cycle after eret_m
    eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    chk("eret_redirect", {31'h0, ret_redirect}, 32'h1);
    chk("eret_flush",    {31'h0, ret_flush},    32'h1);
    chk("eret_ret_pc",   ret_pc,                32'h0040_0010);
    chk("eret_exl",      {31'h0, exl},          32'h0);
    tick();
    chk("eret_redirect_n2", {31'h0, ret_redirect}, 32'h0);
    chk("eret_flush_n2",    {31'h0, ret_flush},    32'h0);

    // ERET outside handler is ignored
    eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    chk("run_eret_redirect", {31'h0, ret_redirect}, 32'h0);
    chk("run_eret_exl",      {31'h0, exl},          32'h0);

    // Re-enter handler with an unaligned PC
    exc_req = 1'b1; exc_code = EXC_OV; exc_pc = 32'h0040_0022;
    tick();
    rd("exc2_epc", REG_EPC, 32'h0040_0020);

    // Nested exception updates only the cause
    exc_code = EXC_RI; exc_pc = 32'h1234_5678;
    tick();
    exc_req = 1'b0;
    rd("nest_cause", REG_CAUSE, 32'h28);
    rd("nest_epc",   REG_EPC,   32'h0040_0020);
    chk("nest_redirect", {31'h0, ret_redirect}, 32'h0);
    chk("nest_exl",      {31'h0, exl},          32'h1);

    // Exception and ERET together: exception wins
    exc_req = 1'b1; exc_code = EXC_OV; eret_m = 1'b1;
    tick();
    exc_req = 1'b0; eret_m = 1'b0;
    chk("both_redirect", {31'h0, ret_redirect}, 32'h0);
    rd("both_cause", REG_CAUSE, 32'h30);
    chk("both_exl", {31'h0, exl}, 32'h1);
    tick();
    chk("both_redirect_late", {31'h0, ret_redirect}, 32'h0);

    // mtc0 EPC in handler: no write-through, masked, changes return target
    mtc0_we = 1'b1; mtc0_addr = REG_EPC; mtc0_wdata = 32'h0000_1003;
    rd("epc_no_wt", REG_EPC, 32'h0040_0020);
    tick();
    mtc0_we = 1'b0;
    rd("mtc0_epc", REG_EPC, 32'h0000_1000);
    chk("mtc0_ret_pc", ret_pc, 32'h0000_1000);

    // ERET, then exception arriving during RETURN alongside an mtc0 EPC write
    eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    chk("eret2_redirect", {31'h0, ret_redirect}, 32'h1);
    chk("eret2_ret_pc",   ret_pc,                32'h0000_1000);
    exc_req = 1'b1; exc_code = EXC_RI; exc_pc = 32'h0000_2006;
    mtc0_we = 1'b1; mtc0_addr = REG_EPC; mtc0_wdata = 32'h0000_ABC0;
    tick();
    exc_req = 1'b0; mtc0_we = 1'b0;
    chk("retexc_redirect", {31'h0, ret_redirect}, 32'h0);
    chk("retexc_exl",      {31'h0, exl},          32'h1);
    rd("retexc_epc",   REG_EPC,   32'h0000_2004);
    rd("retexc_cause", REG_CAUSE, 32'h28);

    // Reset in HANDLER drops everything
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("hrst_exl",      {31'h0, exl},          32'h0);
    chk("hrst_redirect", {31'h0, ret_redirect}, 32'h0);
    rd("hrst_status", REG_STATUS, 32'h1);
    rd("hrst_epc",    REG_EPC,    32'h0);
    tick();
    chk("hrst_redirect_late", {31'h0, ret_redirect}, 32'h0);
    eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    chk("hrst_eret_redirect", {31'h0, ret_redirect}, 32'h0);
    tick();
    chk("hrst_eret_redirect2", {31'h0, ret_redirect}, 32'h0);

    // STATUS write, then STATUS write concurrent with capture
    mtc0_we = 1'b1; mtc0_addr = REG_STATUS; mtc0_wdata = 32'h0;
    tick();
    rd("status_clr", REG_STATUS, 32'h0);
    mtc0_wdata = 32'h1;
    exc_req = 1'b1; exc_code = EXC_OV; exc_pc = 32'h0000_0300;
    tick();
    mtc0_we = 1'b0; exc_req = 1'b0;
    rd("cap_status", REG_STATUS, 32'h3);
    rd("cap_epc",    REG_EPC,    32'h0000_0300);

    // Unimplemented register
    mtc0_we = 1'b1; mtc0_addr = 5'd5; mtc0_wdata = 32'hFFFF_FFFF;
    tick();
    mtc0_we = 1'b0;
    rd("unimpl_5", 5'd5, 32'h0);
    rd("unimpl_cause_kept", REG_CAUSE, 32'h30);

`ifdef CP0_COUNT_EN
    mtc0_we = 1'b1; mtc0_addr = REG_COUNT; mtc0_wdata = 32'hFFFF_FFFE;
    tick();
    mtc0_we = 1'b0;
    rd("count_fe", REG_COUNT, 32'hFFFF_FFFE);
    tick();
    rd("count_ff", REG_COUNT, 32'hFFFF_FFFF);
    tick();
    rd("count_wrap", REG_COUNT, 32'h0);
`else
    rd("count_absent", REG_COUNT, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
